// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operand protocol.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents: data/result/op widths, op-code constants, the driver state
// encoding, and calc_eval(), which defines the unit's arithmetic.
package calc_pkg;

  localparam int DATA_W = 4;
  localparam int RES_W  = 5;
  localparam int OP_W   = 2;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_AND = 2'b10;
  localparam logic [OP_W-1:0] OP_OR  = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BEAT_A = 3'd1,
    BEAT_B = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_e;

  // Subtraction wraps modulo 2^RES_W; logic ops are zero-extended.
  function automatic logic [RES_W-1:0] calc_eval(
    input logic [OP_W-1:0]   op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [RES_W-1:0] ax;
    logic [RES_W-1:0] bx;
    ax = {1'b0, a};
    bx = {1'b0, b};
    case (op)
      OP_ADD:  calc_eval = ax + bx;
      OP_SUB:  calc_eval = ax - bx;
      OP_AND:  calc_eval = ax & bx;
      default: calc_eval = ax | bx;
    endcase
  endfunction

endpackage

// File: rtl/calc_ref_model.sv
// Reference model of the compute unit: expected result for a latched op/a/b.
// Latency: combinational.
// Backpressure: none.
//
// Ports: op_i (op code), a_i / b_i (operands), exp_o (5-bit expected result).
module calc_ref_model
  import calc_pkg::*;
(
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [RES_W-1:0]  exp_o
);

  assign exp_o = calc_eval(op_i, a_i, b_i);

endmodule

// File: rtl/calc_op_driver.sv
// Initiator for the calculator unit: request -> two operand beats -> wait -> response.
// Latency: rsp_valid 3+N cycles after the request handshake cycle (N = unit delay after beat 2).
// Backpressure: response held until rsp_ready; req_ready low while an operation is outstanding.
//
// Ports: clock/rst (sync, active-high); req_* valid/ready request (op, a, b);
// capture/op/d_in beats and valid/result from the compute unit; rsp_* valid/ready
// response with rsp_result and rsp_timeout.
// Optional: define CALC_OP_DRIVER_CHECK_EN to add rsp_mismatch, which flags a unit
// result differing from the internal reference model (0 on timeout).
// TIMEOUT must lie in 1..255 and fit in CNT_W bits.
module calc_op_driver
  import calc_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              capture,
  output logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] d_in,
  input  logic              valid,
  input  logic [RES_W-1:0]  result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_timeout
`ifdef CALC_OP_DRIVER_CHECK_EN
  ,
  output logic              rsp_mismatch
`endif
);

  state_e             state_q;
  logic               req_ready_q;
  logic               capture_q;
  logic [OP_W-1:0]    op_q;
  logic [DATA_W-1:0]  d_q;
  logic [DATA_W-1:0]  b_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               rsp_valid_q;
  logic [RES_W-1:0]   rsp_result_q;
  logic               rsp_timeout_q;
  logic               expire_d;

  // Counter is cleared on the way into WAIT, so it reads k-1 in the k-th WAIT cycle.
  assign expire_d = (cnt_q == CNT_W'(TIMEOUT - 1));

`ifdef CALC_OP_DRIVER_CHECK_EN
  logic [DATA_W-1:0]  a_q;
  logic [RES_W-1:0]   exp_d;
  logic               mismatch_q;

  // op_q still holds the request's op code throughout WAIT.
  calc_ref_model u_ref (
    .op_i  (op_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .exp_o (exp_d)
  );

  assign rsp_mismatch = mismatch_q;
`endif

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      capture_q     <= 1'b0;
      op_q          <= '0;
      d_q           <= '0;
      b_q           <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_timeout_q <= 1'b0;
`ifdef CALC_OP_DRIVER_CHECK_EN
      a_q           <= '0;
      mismatch_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            // Beat 1 goes out straight from the request; B is kept for beat 2.
            op_q        <= req_op;
            d_q         <= req_a;
            b_q         <= req_b;
            capture_q   <= 1'b1;
            req_ready_q <= 1'b0;
            state_q     <= BEAT_A;
`ifdef CALC_OP_DRIVER_CHECK_EN
            a_q         <= req_a;
`endif
          end
        end
        BEAT_A: begin
          d_q     <= b_q;
          state_q <= BEAT_B;
        end
        BEAT_B: begin
          // op/d_in keep their beat-2 values through WAIT.
          capture_q <= 1'b0;
          cnt_q     <= '0;
          state_q   <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // valid takes priority over expiry in the same cycle.
          if (valid) begin
            rsp_result_q  <= result;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
`ifdef CALC_OP_DRIVER_CHECK_EN
            mismatch_q    <= (result != exp_d);
`endif
          end else if (expire_d) begin
            rsp_result_q  <= '0;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
`ifdef CALC_OP_DRIVER_CHECK_EN
            mismatch_q    <= 1'b0;
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          capture_q   <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign capture     = capture_q;
  assign op          = op_q;
  assign d_in        = d_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
